// File: rtl/key_capture.sv
// Push-button front end: two-flop synchroniser, per-key debounce, and sticky
// press flags exposed to the CPU at 0xFFFD with read-to-clear semantics.
module key_capture #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] keys_n,
  input  logic [17:0]       addr,
  input  logic              oe,
  output logic [N_KEYS-1:0] buttons,
  output logic [N_KEYS-1:0] key_level,
  output logic              event_pending
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] s1;
  logic [N_KEYS-1:0] s2;
  logic [N_KEYS-1:0] stable;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] flags;
  logic              rd;
  logic              unused_addr_hi;

  // The decoder ignores the bank bits, so 0xFFFD aliases in every bank.
  assign rd             = (addr[15:0] == 16'hFFFD) && !oe;
  assign unused_addr_hi = ^addr[17:16];

  // Stage boundary: asynchronous pins into the clock domain (1 = pressed).
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ~keys_n;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic [CNT_W-1:0] cnt;
    logic             stable_k;
    logic             flag_k;

    // A press is the edge on which the qualified level is about to rise.
    assign press[i]  = s2[i] && !stable_k && (cnt == CNT_MAX);
    assign stable[i] = stable_k;
    assign flags[i]  = flag_k;

    // Stage boundary: synchronised level into debounced level and event flag.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt      <= '0;
        stable_k <= 1'b0;
        flag_k   <= 1'b0;
      end else begin
        if (s2[i] == stable_k) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          stable_k <= s2[i];
          cnt      <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end

        // Set has priority over the read-clear so a press during a load survives.
        if (press[i]) begin
          flag_k <= 1'b1;
        end else if (rd) begin
          flag_k <= 1'b0;
        end
      end
    end
  end

  assign buttons       = flags;
  assign key_level     = stable;
  assign event_pending = |flags;

endmodule

// File: tb/tb_key_capture.sv
// Directed bench for key_capture with a short debounce window of 4 cycles.
module tb_key_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  keys_n;
  logic [17:0] addr;
  logic        oe;
  logic [3:0]  buttons;
  logic [3:0]  key_level;
  logic        event_pending;

  int n_vec  = 0;
  int n_miss = 0;

  key_capture #(
    .N_KEYS         (4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .keys_n       (keys_n),
    .addr         (addr),
    .oe           (oe),
    .buttons      (buttons),
    .key_level    (key_level),
    .event_pending(event_pending)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %b, expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    reset  = 1'b1;
    keys_n = 4'b0000;
    addr   = 18'h00000;
    oe     = 1'b1;

    // Reset with every key held, then re-qualification.
    tick(1);
    check_val("rst1_buttons", buttons, 4'b0000);
    check_val("rst1_level", key_level, 4'b0000);
    tick(1);
    check_val("rst2_buttons", buttons, 4'b0000);
    check_val("rst2_level", key_level, 4'b0000);
    check_val("rst2_pending", {3'b000, event_pending}, 4'b0000);
    reset = 1'b0;
    tick(5);
    check_val("rst_e5_level", key_level, 4'b0000);
    check_val("rst_e5_buttons", buttons, 4'b0000);
    tick(1);
    check_val("rst_e6_level", key_level, 4'b1111);
    check_val("rst_e6_buttons", buttons, 4'b1111);

    // Release all, then clear the flags.
    keys_n = 4'b1111;
    tick(5);
    check_val("relall_e5_level", key_level, 4'b1111);
    tick(1);
    check_val("relall_e6_level", key_level, 4'b0000);
    check_val("relall_buttons", buttons, 4'b1111);
    addr = 18'h0FFFD; oe = 1'b0;
    tick(1);
    addr = 18'h00000; oe = 1'b1;
    check_val("clr0_buttons", buttons, 4'b0000);
    check_val("clr0_pending", {3'b000, event_pending}, 4'b0000);

    // Single press on key 0 and its release.
    keys_n = 4'b1110;
    tick(5);
    check_val("k0_e5_level", key_level, 4'b0000);
    check_val("k0_e5_buttons", buttons, 4'b0000);
    tick(1);
    check_val("k0_e6_level", key_level, 4'b0001);
    check_val("k0_e6_buttons", buttons, 4'b0001);
    check_val("k0_pending", {3'b000, event_pending}, 4'b0001);
    keys_n = 4'b1111;
    tick(5);
    check_val("k0rel_e5_level", key_level, 4'b0001);
    tick(1);
    check_val("k0rel_e6_level", key_level, 4'b0000);
    check_val("k0rel_buttons", buttons, 4'b0001);

    // Key 1 bouncing every 2 cycles for 20 cycles, then held.
    for (int p = 0; p < 5; p++) begin
      keys_n = 4'b1101;
      tick(2);
      check_val("bounce_lo_level", key_level, 4'b0000);
      keys_n = 4'b1111;
      tick(2);
      check_val("bounce_hi_level", key_level, 4'b0000);
      check_val("bounce_buttons", buttons, 4'b0001);
    end
    keys_n = 4'b1101;
    tick(5);
    check_val("k1_e5_level", key_level, 4'b0000);
    tick(1);
    check_val("k1_e6_level", key_level, 4'b0010);
    check_val("k1_e6_buttons", buttons, 4'b0011);
    keys_n = 4'b1111;
    tick(6);
    check_val("k1rel_level", key_level, 4'b0000);

    // Read-clear, store and wrong-address cases with flags at 0101.
    addr = 18'h0FFFD; oe = 1'b0;
    tick(1);
    addr = 18'h00000; oe = 1'b1;
    check_val("clr1_buttons", buttons, 4'b0000);
    keys_n = 4'b1010;
    tick(6);
    check_val("k02_level", key_level, 4'b0101);
    check_val("k02_buttons", buttons, 4'b0101);
    keys_n = 4'b1111;
    tick(6);
    addr = 18'h0FFFD; oe = 1'b1;
    tick(1);
    check_val("store_noclr", buttons, 4'b0101);
    addr = 18'h0FFFE; oe = 1'b0;
    tick(1);
    check_val("addr_noclr", buttons, 4'b0101);
    addr = 18'h0FFFD; oe = 1'b0;
    tick(1);
    addr = 18'h00000; oe = 1'b1;
    check_val("load_clr", buttons, 4'b0000);
    check_val("load_clr_pending", {3'b000, event_pending}, 4'b0000);

    // Set wins over a same-edge read; bank bits of addr are ignored.
    keys_n = 4'b1110;
    tick(6);
    check_val("sw_k0_buttons", buttons, 4'b0001);
    keys_n = 4'b1111;
    tick(6);
    keys_n = 4'b1011;
    tick(5);
    check_val("sw_pre_buttons", buttons, 4'b0001);
    addr = 18'h3FFFD; oe = 1'b0;
    tick(1);
    check_val("sw_buttons", buttons, 4'b0100);
    check_val("sw_level", key_level, 4'b0100);
    tick(1);
    check_val("held_rd_clr", buttons, 4'b0000);
    addr = 18'h00000; oe = 1'b1;
    keys_n = 4'b1111;
    tick(6);
    check_val("sw_rel_level", key_level, 4'b0000);

    // Reset arriving mid-debounce on key 3.
    keys_n = 4'b0111;
    tick(3);
    check_val("mid_pre_level", key_level, 4'b0000);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_val("mid_rst_buttons", buttons, 4'b0000);
    tick(5);
    check_val("mid_e5_buttons", buttons, 4'b0000);
    check_val("mid_e5_level", key_level, 4'b0000);
    tick(1);
    check_val("mid_e6_buttons", buttons, 4'b1000);
    check_val("mid_e6_level", key_level, 4'b1000);
    check_val("mid_pending", {3'b000, event_pending}, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
